dynamic_crop: RTL and testbench
===============================

# dynamic_crop

Runtime-programmable, multi-channel crop stage for the camera pixel pipeline. It generalises the fixed-window pan and zoom crops. Window coordinates are loaded over a register interface and double-buffered, so a window change never takes effect mid-frame. Data width, channel count and coordinate width are parameters, so one module serves the raw Bayer stage (1 channel) and the debayered RGB stage (3 channels).

## Interface
Parameters:
- CHANNELS, 3, number of parallel pixel channels
- DATA_WIDTH, 10, bits per channel
- COORD_WIDTH, 11, bits per coordinate and counter

Ports:
- clock_in  input  1  pixel clock; all logic is in this single domain
- reset_n_in  input  1  reset, asynchronous and active-low
- data_in  input  CHANNELS*DATA_WIDTH  pixel data; channel 0 is in the LSBs
- line_valid_in  input  1  high for each active pixel of a line
- frame_valid_in  input  1  high for the duration of a frame
- x_start_in, x_end_in, y_start_in, y_end_in  input  COORD_WIDTH each  requested window (start inclusive, end exclusive)
- window_load_in  input  1  single-cycle pulse; captures the four coordinates into the pending registers
- data_out  output  CHANNELS*DATA_WIDTH  cropped pixel data
- line_valid_out  output  1  qualifies data_out
- frame_valid_out  output  1  frame_valid_in delayed to match data_out
- frame_done_out  output  1  one-cycle pulse at the end of each forwarded frame
- window_error_out  output  1  high while the active window is empty

## Operation
- The block has two register sets:
  - pending: written on window_load_in.
  - active: copied from pending on the rising edge of frame_valid_in, and only when the FSM is in WAIT_FRAME.
- A load and a frame-start edge in the same cycle: the frame uses the old active window; the new values apply from the next frame.
- Reset value of both register sets: start = 0, end = 2^COORD_WIDTH-1.
- FSM:
  - SYNC (entered after reset): wait for frame_valid_in = 0, then go to WAIT_FRAME.
  - WAIT_FRAME: on frame_valid_in 0→1, apply pending to active and go to IN_FRAME.
  - IN_FRAME: on frame_valid_in 1→0, pulse frame_done_out and go to WAIT_FRAME.
  - Consequence: a frame already in progress when reset is released is discarded entirely.
- Counters:
  - x counts line_valid_in cycles within a line and clears on line_valid_in 1→0.
  - y increments on line_valid_in 1→0 and clears in WAIT_FRAME.
  - Both saturate at 2^COORD_WIDTH-1; they never wrap.
- A pixel is forwarded when x_start ≤ x < x_end and y_start ≤ y < y_end, using the x and y values before that cycle's increment.
- data_out updates only on forwarded pixels; otherwise it holds its last value.
- window_error_out = (x_start ≥ x_end) or (y_start ≥ y_end) on the active set.
  - It updates when the active set is loaded.
  - An empty window forwards no pixels, but frame_valid_out and frame_done_out still toggle normally.
- Only frame_valid_out is forwarded outside IN_FRAME; line_valid_out stays 0.

## Timing
- Reset values: data_out = 0, line_valid_out = 0, frame_valid_out = 0, frame_done_out = 0, window_error_out = 0, FSM in SYNC.
- Latency is 1 clock from data_in/line_valid_in to data_out/line_valid_out. frame_valid_out is frame_valid_in registered once.
- frame_done_out is asserted in the cycle where frame_valid_out falls.
- Throughput is one pixel per clock, with no backpressure.
- Reset asserted mid-frame: all outputs go to 0 immediately; the pending and active registers return to their reset values.

## Configuration
- DYNAMIC_CROP_DECIMATE_EN defined:
  - Adds input port decimate_in (1 bit), captured into the pending set on window_load_in and shadowed like the coordinates.
  - When the active decimate bit is 1, a pixel is forwarded only if it is inside the window and both (x − x_start) and (y − y_start) are even.
  - A window of W×H forwards ceil(W/2)×ceil(H/2) pixels.
- DYNAMIC_CROP_DECIMATE_EN undefined: the port is absent and behaviour is identical to decimate = 0.

## Test plan
- Window test: 16×12 frame, window x 4..12, y 2..10, data = x.
  - Required: 8 lines of 8 pixels; the first data_out of each line is 4; line_valid_out lags line_valid_in by 1 clock; exactly one frame_done_out pulse.
- Mid-frame load: load x 0..4 during a frame that uses window x 4..12.
  - Required: the current frame still emits 8-pixel lines; the next frame emits 4-pixel lines.
- Empty window: x_start = x_end = 5.
  - Required: window_error_out = 1 from the next frame start; no line_valid_out pulses; frame_valid_out and frame_done_out still toggle.
- Reset mid-frame: assert reset_n_in at line 5 and release it at line 7.
  - Required: all outputs are 0 during reset; the remainder of that frame is not forwarded; the following frame is cropped with the full default window.
- Saturation: 16×12 frame with COORD_WIDTH = 3 and window x 0..7.
  - Required: 7 pixels per line; no wrap-around re-entry into the window.
- With DYNAMIC_CROP_DECIMATE_EN: window 4..12 × 2..10 with decimate = 1.
  - Required: 4 lines of 4 pixels, with data values 4, 6, 8, 10.

Source files
------------

// File: rtl/dynamic_crop.sv
// rtl/dynamic_crop.sv - runtime-programmable multi-channel crop with double-buffered window
// Optional feature: DYNAMIC_CROP_DECIMATE_EN adds 2:1 decimation inside the window.
module dynamic_crop #(
  parameter int CHANNELS    = 3,
  parameter int DATA_WIDTH  = 10,
  parameter int COORD_WIDTH = 11
) (
  input  logic                           clock_in,
  input  logic                           reset_n_in,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           line_valid_in,
  input  logic                           frame_valid_in,
  input  logic [COORD_WIDTH-1:0]         x_start_in,
  input  logic [COORD_WIDTH-1:0]         x_end_in,
  input  logic [COORD_WIDTH-1:0]         y_start_in,
  input  logic [COORD_WIDTH-1:0]         y_end_in,
`ifdef DYNAMIC_CROP_DECIMATE_EN
  input  logic                           decimate_in,
`endif
  input  logic                           window_load_in,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                           line_valid_out,
  output logic                           frame_valid_out,
  output logic                           frame_done_out,
  output logic                           window_error_out
);

  localparam logic [COORD_WIDTH-1:0] CMAX = '1;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] xs;
    logic [COORD_WIDTH-1:0] xe;
    logic [COORD_WIDTH-1:0] ys;
    logic [COORD_WIDTH-1:0] ye;
    logic                   dec;
  } win_t;

  localparam win_t WIN_RESET = '{xs: '0, xe: CMAX, ys: '0, ye: CMAX, dec: 1'b0};

  typedef enum logic [1:0] {
    SYNC       = 2'd0,
    WAIT_FRAME = 2'd1,
    IN_FRAME   = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  win_t                          pend_q, pend_d;
  win_t                          act_q, act_d;
  logic [COORD_WIDTH-1:0]        x_q, x_d;
  logic [COORD_WIDTH-1:0]        y_q, y_d;
  logic                          lv_prev_q;
  logic                          fv_q;
  logic [CHANNELS*DATA_WIDTH-1:0] data_q, data_d;
  logic                          lv_out_q, lv_out_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;

  logic fv_rise;
  logic fv_fall;
  logic in_window;
  logic keep_pixel;

  function automatic logic [COORD_WIDTH-1:0] sat_inc(input logic [COORD_WIDTH-1:0] v);
    sat_inc = (v == CMAX) ? v : v + 1'b1;
  endfunction

  function automatic logic is_empty(input win_t w);
    is_empty = (w.xs >= w.xe) || (w.ys >= w.ye);
  endfunction

  assign fv_rise = frame_valid_in & ~fv_q;
  assign fv_fall = ~frame_valid_in & fv_q;

  assign in_window = (x_q >= act_q.xs) && (x_q < act_q.xe) &&
                     (y_q >= act_q.ys) && (y_q < act_q.ye);

  // Even offsets from the window origin share parity with the origin itself.
  assign keep_pixel = !act_q.dec ||
                      ((x_q[0] == act_q.xs[0]) && (y_q[0] == act_q.ys[0]));

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    act_d    = act_q;
    err_d    = err_q;
    done_d   = 1'b0;
    lv_out_d = 1'b0;
    data_d   = data_q;
    x_d      = line_valid_in ? sat_inc(x_q) : '0;
    y_d      = y_q;

    if (window_load_in) begin
      pend_d.xs = x_start_in;
      pend_d.xe = x_end_in;
      pend_d.ys = y_start_in;
      pend_d.ye = y_end_in;
`ifdef DYNAMIC_CROP_DECIMATE_EN
      pend_d.dec = decimate_in;
`else
      pend_d.dec = 1'b0;
`endif
    end

    unique case (state_q)
      SYNC: begin
        y_d = '0;
        if (!frame_valid_in) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        y_d = '0;
        // pend_q is the pre-load value, so a same-cycle load waits a frame.
        if (fv_rise) begin
          act_d   = pend_q;
          err_d   = is_empty(pend_q);
          state_d = IN_FRAME;
        end
      end
      IN_FRAME: begin
        if (lv_prev_q && !line_valid_in) y_d = sat_inc(y_q);
        if (line_valid_in && in_window && keep_pixel) begin
          lv_out_d = 1'b1;
          data_d   = data_in;
        end
        if (fv_fall) begin
          done_d  = 1'b1;
          state_d = WAIT_FRAME;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= SYNC;
      pend_q    <= WIN_RESET;
      act_q     <= WIN_RESET;
      x_q       <= '0;
      y_q       <= '0;
      lv_prev_q <= 1'b0;
      fv_q      <= 1'b0;
      data_q    <= '0;
      lv_out_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
      x_q       <= x_d;
      y_q       <= y_d;
      lv_prev_q <= line_valid_in;
      fv_q      <= frame_valid_in;
      data_q    <= data_d;
      lv_out_q  <= lv_out_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign data_out         = data_q;
  assign line_valid_out   = lv_out_q;
  assign frame_valid_out  = fv_q;
  assign frame_done_out   = done_q;
  assign window_error_out = err_q;

endmodule

// File: tb/tb_dynamic_crop.sv
// tb/tb_dynamic_crop.sv - scoreboard bench for dynamic_crop
module tb_dynamic_crop;

  localparam int CH = 3;
  localparam int DW = 10;
  localparam int CW = 11;
  localparam int PW = CH * DW;
  localparam int DEF_END = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [PW-1:0] din;
  logic          lv, fv, load;
  logic [CW-1:0] xs, xe, ys, ye;
  logic [PW-1:0] dout;
  logic          lvo, fvo, done, err;

  logic [2:0]    s_lo, s_hi;
  logic [DW-1:0] s_dout;
  logic          s_lvo, s_fvo, s_done, s_err;

`ifdef DYNAMIC_CROP_DECIMATE_EN
  logic dec_s;
  logic s_dec;
`endif

  dynamic_crop #(.CHANNELS(CH), .DATA_WIDTH(DW), .COORD_WIDTH(CW)) dut (
    .clock_in(clk), .reset_n_in(rst_n), .data_in(din),
    .line_valid_in(lv), .frame_valid_in(fv),
    .x_start_in(xs), .x_end_in(xe), .y_start_in(ys), .y_end_in(ye),
`ifdef DYNAMIC_CROP_DECIMATE_EN
    .decimate_in(dec_s),
`endif
    .window_load_in(load),
    .data_out(dout), .line_valid_out(lvo), .frame_valid_out(fvo),
    .frame_done_out(done), .window_error_out(err)
  );

  dynamic_crop #(.CHANNELS(1), .DATA_WIDTH(DW), .COORD_WIDTH(3)) dut_sat (
    .clock_in(clk), .reset_n_in(rst_n), .data_in(din[DW-1:0]),
    .line_valid_in(lv), .frame_valid_in(fv),
    .x_start_in(s_lo), .x_end_in(s_hi), .y_start_in(s_lo), .y_end_in(s_hi),
`ifdef DYNAMIC_CROP_DECIMATE_EN
    .decimate_in(s_dec),
`endif
    .window_load_in(1'b0),
    .data_out(s_dout), .line_valid_out(s_lvo), .frame_valid_out(s_fvo),
    .frame_done_out(s_done), .window_error_out(s_err)
  );

  typedef struct {
    logic [PW-1:0] d;
    int            c;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pix_out = 0, done_cnt = 0;
  int   s_pix = 0, s_lines = 0, s_cur = 0, s_bad_len = 0, s_done_cnt = 0;
  logic fvo_prev = 1'b0;

  int   mp_xs, mp_xe, mp_ys, mp_ye;
  int   ma_xs, ma_xe, ma_ys, ma_ye;
  logic mp_dec, ma_dec;
  logic m_err = 1'b0;
  logic m_on = 1'b0;
  logic m_ready = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (lvo === 1'b1) begin
      pix_out++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pixel data=%h cycle=%0d expected no output", dout, cyc);
      end else begin
        e = sb.pop_front();
        if (dout !== e.d || cyc !== e.c) begin
          n_fail++;
          $display("FAIL pixel data=%h cycle=%0d expected data=%h cycle=%0d", dout, cyc, e.d, e.c);
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      n_checks++;
      if (!(fvo === 1'b0 && fvo_prev === 1'b1)) begin
        n_fail++;
        $display("FAIL done_align fvo=%b prev=%b expected fvo=0 prev=1", fvo, fvo_prev);
      end
    end
    fvo_prev = fvo;
    if (s_lvo === 1'b1) begin
      s_pix++;
      s_cur++;
    end else if (s_cur > 0) begin
      s_lines++;
      if (s_cur != 7) s_bad_len++;
      s_cur = 0;
    end
    if (s_done === 1'b1) s_done_cnt++;
  end

  task automatic model_reset();
    mp_xs = 0; mp_xe = DEF_END; mp_ys = 0; mp_ye = DEF_END; mp_dec = 1'b0;
    ma_xs = 0; ma_xe = DEF_END; ma_ys = 0; ma_ye = DEF_END; ma_dec = 1'b0;
    m_err = 1'b0; m_on = 1'b0; m_ready = 1'b0;
  endtask

  task automatic drive_cycle(input logic lv_v, input logic fv_v, input int x, input int y);
    exp_t e;
    lv  = lv_v;
    fv  = fv_v;
    din = {DW'(x ^ y), DW'(y), DW'(x)};
    if (m_on && lv_v && x >= ma_xs && x < ma_xe && y >= ma_ys && y < ma_ye &&
        (!ma_dec || (((x - ma_xs) % 2) == 0 && ((y - ma_ys) % 2) == 0))) begin
      e.d = din;
      e.c = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    lv = 1'b0;
    fv = 1'b0;
    repeat (n) @(negedge clk);
    if (n >= 2 && rst_n) m_ready = 1'b1;
  endtask

  task automatic set_window(input int a, input int b, input int c, input int d, input logic dv);
    xs = CW'(a); xe = CW'(b); ys = CW'(c); ye = CW'(d);
`ifdef DYNAMIC_CROP_DECIMATE_EN
    dec_s = dv;
`endif
    mp_xs = a; mp_xe = b; mp_ys = c; mp_ye = d; mp_dec = dv;
  endtask

  task automatic do_load(input int a, input int b, input int c, input int d, input logic dv);
    set_window(a, b, c, d, dv);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int ld_line,
                            input int la, input int lb, input int lc, input int ld,
                            input int rst_line, input int rst_end);
    if (m_ready) begin
      ma_xs = mp_xs; ma_xe = mp_xe; ma_ys = mp_ys; ma_ye = mp_ye; ma_dec = mp_dec;
      m_err = (mp_xs >= mp_xe) || (mp_ys >= mp_ye);
      m_on  = 1'b1;
    end else begin
      m_on = 1'b0;
    end
    m_ready = 1'b0;
    drive_cycle(1'b0, 1'b1, 0, 0);
    drive_cycle(1'b0, 1'b1, 0, 0);
    for (int y = 0; y < h; y++) begin
      for (int b = 0; b < 2; b++) begin
        if (y == ld_line && b == 0) begin
          set_window(la, lb, lc, ld, 1'b0);
          load = 1'b1;
        end
        if (y == rst_line && b == 1) begin
          rst_n = 1'b0;
          model_reset();
          #1;
          n_checks++;
          if ({dout, lvo, fvo, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs data=%h lv=%b fv=%b done=%b err=%b expected all 0",
                     dout, lvo, fvo, done, err);
          end
        end
        if (y == rst_end && b == 1) rst_n = 1'b1;
        drive_cycle(1'b0, 1'b1, 0, y);
        load = 1'b0;
      end
      for (int x = 0; x < w; x++) drive_cycle(1'b1, 1'b1, x, y);
    end
    drive_cycle(1'b0, 1'b1, 0, 0);
    drive_cycle(1'b0, 1'b1, 0, 0);
    m_on = 1'b0;
  endtask

  task automatic check_frame(input string name, input int pix0, input int done0,
                             input int exp_pix, input int exp_done);
    n_checks++;
    if (pix_out - pix0 !== exp_pix) begin
      n_fail++;
      $display("FAIL %s_pixels got=%0d expected=%0d", name, pix_out - pix0, exp_pix);
    end
    n_checks++;
    if (done_cnt - done0 !== exp_done) begin
      n_fail++;
      $display("FAIL %s_done got=%0d expected=%0d", name, done_cnt - done0, exp_done);
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_missing got=%0d pending expected=0", name, sb.size());
      sb.delete();
    end
    n_checks++;
    if (err !== m_err) begin
      n_fail++;
      $display("FAIL %s_window_error got=%b expected=%b", name, err, m_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (dout !== '0) begin n_fail++; $display("FAIL reset_data got=%h expected=0", dout); end
    n_checks++;
    if (lvo !== 1'b0) begin n_fail++; $display("FAIL reset_lv got=%b expected=0", lvo); end
    n_checks++;
    if (fvo !== 1'b0) begin n_fail++; $display("FAIL reset_fv got=%b expected=0", fvo); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b expected=0", done); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b expected=0", err); end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_window();
    int p0, d0;
    do_load(4, 12, 2, 10, 1'b0);
    idle(2);
    p0 = pix_out; d0 = done_cnt;
    send_frame(16, 12, -1, 0, 0, 0, 0, -1, -1);
    idle(4);
    check_frame("window", p0, d0, 64, 1);
  endtask

  task automatic test_mid_frame_load();
    int p0, d0;
    p0 = pix_out; d0 = done_cnt;
    send_frame(16, 12, 3, 0, 4, 2, 10, -1, -1);
    idle(4);
    check_frame("midload_cur", p0, d0, 64, 1);
    p0 = pix_out; d0 = done_cnt;
    send_frame(16, 12, -1, 0, 0, 0, 0, -1, -1);
    idle(4);
    check_frame("midload_next", p0, d0, 32, 1);
  endtask

  task automatic test_empty_window();
    int p0, d0;
    do_load(5, 5, 2, 10, 1'b0);
    idle(2);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_err_before_frame got=%b expected=0", err);
    end
    p0 = pix_out; d0 = done_cnt;
    send_frame(16, 12, -1, 0, 0, 0, 0, -1, -1);
    idle(4);
    check_frame("empty", p0, d0, 0, 1);
  endtask

  task automatic test_reset_mid_frame();
    int p0, d0;
    do_load(4, 12, 0, 12, 1'b0);
    idle(2);
    p0 = pix_out; d0 = done_cnt;
    send_frame(16, 12, -1, 0, 0, 0, 0, 5, 7);
    idle(4);
    check_frame("rst_frame", p0, d0, 40, 0);
    p0 = pix_out; d0 = done_cnt;
    send_frame(16, 12, -1, 0, 0, 0, 0, -1, -1);
    idle(4);
    check_frame("rst_next", p0, d0, 192, 1);
  endtask

  task automatic test_saturation();
    int p0, d0;
    s_pix = 0; s_lines = 0; s_cur = 0; s_bad_len = 0; s_done_cnt = 0;
    p0 = pix_out; d0 = done_cnt;
    send_frame(16, 12, -1, 0, 0, 0, 0, -1, -1);
    idle(4);
    check_frame("sat_main", p0, d0, 192, 1);
    n_checks++;
    if (s_pix !== 49) begin n_fail++; $display("FAIL sat_pixels got=%0d expected=49", s_pix); end
    n_checks++;
    if (s_lines !== 7) begin n_fail++; $display("FAIL sat_lines got=%0d expected=7", s_lines); end
    n_checks++;
    if (s_bad_len !== 0) begin n_fail++; $display("FAIL sat_line_len bad=%0d expected=0", s_bad_len); end
    n_checks++;
    if (s_dout !== DW'(6)) begin n_fail++; $display("FAIL sat_last_data got=%0d expected=6", s_dout); end
    n_checks++;
    if (s_done_cnt !== 1) begin n_fail++; $display("FAIL sat_done got=%0d expected=1", s_done_cnt); end
    n_checks++;
    if (s_err !== 1'b0 || s_fvo !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_idle err=%b fv=%b expected 0 0", s_err, s_fvo);
    end
  endtask

`ifdef DYNAMIC_CROP_DECIMATE_EN
  task automatic test_decimate();
    int p0, d0;
    do_load(4, 12, 2, 10, 1'b1);
    idle(2);
    p0 = pix_out; d0 = done_cnt;
    send_frame(16, 12, -1, 0, 0, 0, 0, -1, -1);
    idle(4);
    check_frame("decimate", p0, d0, 16, 1);
  endtask
`endif

  initial begin
    rst_n = 1'b0; din = '0; lv = 1'b0; fv = 1'b0; load = 1'b0;
    xs = '0; xe = '0; ys = '0; ye = '0;
    s_lo = 3'd0; s_hi = 3'd7;
`ifdef DYNAMIC_CROP_DECIMATE_EN
    dec_s = 1'b0;
    s_dec = 1'b0;
`endif
    test_reset();
    test_window();
    test_mid_frame_load();
    test_empty_window();
    test_reset_mid_frame();
    test_saturation();
`ifdef DYNAMIC_CROP_DECIMATE_EN
    test_decimate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
